// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the queued write-back entry type for reg_writeback_ctrl
package wb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   wd;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t; pushes when full and pops when empty are ignored
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  wb_entry_t                i_din,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output wb_entry_t                o_head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   L_CONE = (AW+1)'(1);
   localparam logic [AW-1:0] L_PONE = AW'(1);

   wb_entry_t     r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == L_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rp];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end

   // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + L_PONE;
         if (w_pop)  r_rp <= r_rp + L_PONE;
         r_count <= (w_push && !w_pop) ? r_count + L_CONE :
                    (w_pop && !w_push) ? r_count - L_CONE : r_count;
      end
   end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges ALU and LSU results onto the register file write port and tracks pending destinations.
// Optional WB_LSU_BYPASS_EN: an LSU result skips the empty FIFO when the ALU leaves the slot free.
module reg_writeback_ctrl
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_alu_valid,
   input  logic [4:0]              i_alu_rd,
   input  logic [XLEN-1:0]         i_alu_wd,
   input  logic                    i_lsu_valid,
   output logic                    o_lsu_ready,
   input  logic [4:0]              i_lsu_rd,
   input  logic [XLEN-1:0]         i_lsu_wd,
   input  logic                    i_issue_valid,
   input  logic [4:0]              i_issue_rd,
   input  logic [4:0]              i_q1_addr,
   input  logic [4:0]              i_q2_addr,
   output logic                    o_q1_pending,
   output logic                    o_q2_pending,
   output logic                    o_rf_we,
   output logic [4:0]              o_rf_addr,
   output logic [XLEN-1:0]         o_rf_wd,
   output logic [$clog2(DEPTH):0]  o_fifo_count
);
   logic             w_full;
   logic             w_empty;
   logic             w_alu_win;
   logic             w_lsu_acc;
   logic             w_pop;
   logic             w_byp;
   logic             w_push;
   logic             w_win;
   wb_entry_t        w_head;
   wb_entry_t        w_alu_e;
   wb_entry_t        w_lsu_e;
   wb_entry_t        w_win_e;
   logic [NREGS-1:0] r_pending;
   logic [NREGS-1:0] w_pend_nxt;

   assign o_lsu_ready = !w_full;
   assign w_alu_e     = {i_alu_rd, i_alu_wd};
   assign w_lsu_e     = {i_lsu_rd, i_lsu_wd};
   assign w_alu_win   = i_alu_valid && (i_alu_rd != '0);
   assign w_lsu_acc   = i_lsu_valid && o_lsu_ready && (i_lsu_rd != '0);
   assign w_pop       = !w_alu_win && !w_empty;
`ifdef WB_LSU_BYPASS_EN
   assign w_byp       = !w_alu_win && w_empty && w_lsu_acc;
`else
   assign w_byp       = 1'b0;
`endif
   assign w_push      = w_lsu_acc && !w_byp;
   assign w_win       = w_alu_win || w_pop || w_byp;
   assign w_win_e     = w_alu_win ? w_alu_e : w_pop ? w_head : w_lsu_e;

   assign o_q1_pending = (i_q1_addr != '0) && r_pending[i_q1_addr];
   assign o_q2_pending = (i_q2_addr != '0) && r_pending[i_q2_addr];

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (w_lsu_e),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifo_count),
      .o_head  (w_head)
   );

   // Scoreboard next state: retire the write being presented, then a new issue re-arms (set wins)
   always_comb begin
      w_pend_nxt = r_pending;
      if (o_rf_we) w_pend_nxt[o_rf_addr] = 1'b0;
      if (i_issue_valid && (i_issue_rd != '0)) w_pend_nxt[i_issue_rd] = 1'b1;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= w_pend_nxt;
   end

   // Write-port register; address/data hold when the slot is idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rf_we   <= 1'b0;
         o_rf_addr <= '0;
         o_rf_wd   <= '0;
      end else begin
         o_rf_we <= w_win;
         if (w_win) {o_rf_addr, o_rf_wd} <= w_win_e;
      end
   end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed and random checks of reg_writeback_ctrl against a queue-based reference model
module tb_reg_writeback_ctrl;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, lsu_valid, issue_valid;
   logic [4:0]  alu_rd, lsu_rd, issue_rd, q1_addr, q2_addr;
   logic [31:0] alu_wd, lsu_wd;
   logic        lsu_ready, q1_pending, q2_pending, rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wd;
   logic [2:0]  fifo_count;

   int n_chk = 0;
   int n_err = 0;

   typedef struct { logic [4:0] rd; logic [31:0] wd; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pend;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_wd;

   reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_wd(alu_wd),
      .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_wd(lsu_wd),
      .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
      .i_q1_addr(q1_addr), .i_q2_addr(q2_addr),
      .o_q1_pending(q1_pending), .o_q2_pending(q2_pending),
      .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_wd(rf_wd), .o_fifo_count(fifo_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pend = '0;
      m_we   = 1'b0;
      m_addr = '0;
      m_wd   = '0;
   endtask

   // One clock cycle: drive, check combinational outputs, advance the model, check registered outputs
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] qa, input logic [4:0] qb);
      bit   rdy, hs, win, byp;
      ent_t w;
      alu_valid = av;  alu_rd = ard;  alu_wd = awd;
      lsu_valid = lv;  lsu_rd = lrd;  lsu_wd = lwd;
      issue_valid = iv; issue_rd = ird;
      q1_addr = qa; q2_addr = qb;
      #1;
      rdy = (m_q.size() != DEPTH);
      check("lsu_ready", lsu_ready, rdy);
      check("q1_pending", q1_pending, (qa != 0) && m_pend[qa]);
      check("q2_pending", q2_pending, (qb != 0) && m_pend[qb]);
      hs  = lv && rdy;
      win = 0;
      byp = 0;
      w   = '{5'd0, 32'd0};
      if (av && ard != 0) begin
         win = 1; w = '{ard, awd};
      end else if (m_q.size() > 0) begin
         win = 1; w = m_q.pop_front();
      end
`ifdef WB_LSU_BYPASS_EN
      else if (hs && lrd != 0) begin
         win = 1; byp = 1; w = '{lrd, lwd};
      end
`endif
      if (hs && lrd != 0 && !byp) m_q.push_back('{lrd, lwd});
      if (m_we) m_pend[m_addr] = 1'b0;
      if (iv && ird != 0) m_pend[ird] = 1'b1;
      m_we = win;
      if (win) begin
         m_addr = w.rd;
         m_wd   = w.wd;
      end
      @(posedge clk);
      #1;
      check("rf_we", rf_we, m_we);
      check("rf_addr", rf_addr, m_addr);
      check("rf_wd", rf_wd, m_wd);
      check("fifo_count", fifo_count, m_q.size());
      check("x0_write", rf_we && (rf_addr == 0), 0);
   endtask

   task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
      step(0, 0, 0, 0, 0, 0, 0, 0, qa, qb);
   endtask

   // Stimulus sequence
   initial begin
      rst_n = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_wd = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
      issue_valid = 0; issue_rd = 0; q1_addr = 0; q2_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_we", rf_we, 0);
      check("rst_addr", rf_addr, 0);
      check("rst_wd", rf_wd, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", lsu_ready, 1);
      rst_n = 1'b1;

      // ALU only
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      check("alu_we", rf_we, 1);
      check("alu_addr", rf_addr, 5);
      check("alu_wd", rf_wd, 32'hDEADBEEF);
      idle(0, 0);
      check("alu_we_drop", rf_we, 0);

      // ALU hogs the slot while LSU fills the FIFO, then drains in order
      for (int i = 0; i < 4; i++) step(1, 5'(20 + i), $urandom, 1, 5'(6 + i), 32'hA0 + i, 0, 0, 0, 0);
      check("full_count", fifo_count, 4);
      check("full_ready", lsu_ready, 0);
      step(1, 24, $urandom, 1, 11, 32'hBAD, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         idle(0, 0);
         check("drain_addr", rf_addr, 6 + i);
         check("drain_wd", rf_wd, 32'hA0 + i);
      end
      idle(0, 0);

      // x0: dropped ALU write lets the queued entry pop; LSU write to x0 is discarded
      step(1, 1, 32'h11, 1, 3, 32'h33, 0, 0, 0, 0);
      step(1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0);
      check("x0_pop_addr", rf_addr, 3);
      check("x0_pop_wd", rf_wd, 32'h33);
      step(0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0);
      check("x0_lsu_count", fifo_count, 0);
      check("x0_lsu_we", rf_we, 0);
      idle(0, 0);

      // Scoreboard set/clear, including re-issue on the clearing edge
      step(0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
      step(1, 10, 32'h10, 0, 0, 0, 0, 0, 10, 0);
      check("sb_busy", q1_pending, 1);
      step(0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
      check("sb_reissue", q1_pending, 1);
      step(1, 10, 32'h20, 0, 0, 0, 0, 0, 10, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
      check("sb_clear", q1_pending, 0);
      idle(0, 0);

      // Empty FIFO, idle ALU: LSU latency depends on the bypass option
      step(0, 0, 0, 1, 4, 32'h1234, 0, 0, 0, 0);
`ifdef WB_LSU_BYPASS_EN
      check("byp_we", rf_we, 1);
      check("byp_addr", rf_addr, 4);
      check("byp_count", fifo_count, 0);
`else
      check("nobyp_we", rf_we, 0);
      check("nobyp_count", fifo_count, 1);
      idle(0, 0);
      check("nobyp_addr", rf_addr, 4);
`endif
      idle(0, 0);

      // Reset mid-run with queued entries and pending bits
      for (int i = 0; i < 3; i++) step(1, 5'(14 + i), $urandom, 1, 5'(25 + i), $urandom, 1, 5'(12 + i), 12, 13);
      check("pre_rst_count", fifo_count, 3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_we", rf_we, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_q1", q1_pending, 0);
      check("mid_rst_q2", q2_pending, 0);
      alu_valid = 0; lsu_valid = 0; issue_valid = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) idle(12, 13);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 99) < 40, 5'($urandom_range(0, 15)),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
Writer-side controller for the 32x32 register file write port (WE3/A3/WD3).
- Merges results from two sources: the single-cycle ALU and the variable-latency load/store unit (LSU).
- Buffers LSU results in a small FIFO and issues at most one register write per cycle.
- Keeps a pending-destination scoreboard so the decode stage can stall on registers that are still in flight.

Parameters:
- XLEN, 32, data width of a register write.
- DEPTH, 4, LSU result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, has no ready.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  XLEN  ALU result data.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  LSU result accepted when lsu_valid and lsu_ready are both high.
- lsu_rd  in  5  LSU destination register.
- lsu_wd  in  XLEN  LSU result data.
- issue_valid  in  1  decode issued an instruction that writes issue_rd.
- issue_rd  in  5  destination register of the issued instruction.
- q1_addr  in  5  scoreboard query address 1 (rs1).
- q2_addr  in  5  scoreboard query address 2 (rs2).
- q1_pending  out  1  combinational: register q1_addr has a write in flight.
- q2_pending  out  1  combinational: register q2_addr has a write in flight.
- rf_we  out  1  registered; drives register file WE3.
- rf_addr  out  5  registered; drives A3.
- rf_wd  out  XLEN  registered; drives WD3.
- fifo_count  out  $clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_addr=0, rf_wd=0.
  - FIFO emptied; fifo_count=0.
  - pending[31:0]=0.
  - lsu_ready reads 1 once the FIFO is empty.
  - Reset asserted mid-operation discards all queued and in-flight writes.
- Slot selection, each cycle:
  - If alu_valid and alu_rd!=0: the ALU wins the slot.
  - Otherwise, if the FIFO is non-empty: pop the head, which wins the slot.
  - Otherwise: no slot.
- Output update: at the next edge, rf_we<=1 and rf_addr/rf_wd<=winner. With no winner, rf_we<=0 and rf_addr/rf_wd hold their values.
- Latency: an ALU result is presented on rf_* one cycle after alu_valid. The register file captures it at the following edge.
- x0 handling:
  - alu_valid with alu_rd==0 is dropped and does not take the slot, so the FIFO may pop in that cycle.
  - An LSU handshake with lsu_rd==0 is accepted and discarded; nothing is pushed.
  - rf_we is never asserted with rf_addr==0.
- FIFO:
  - lsu_ready = (fifo_count != DEPTH), computed from registered state only.
  - A push is not accepted when full, even if a pop occurs in the same cycle (no full-bypass).
  - A simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Order is strict FIFO.
  - An LSU result can wait indefinitely if the ALU writes every cycle; no fairness is provided.
- Scoreboard:
  - Set: issue_valid with issue_rd!=0 sets pending[issue_rd].
  - Clear: pending[rf_addr] clears at each edge where rf_we=1, i.e. the same edge at which the register file captures the write.
  - Set and clear of the same register at one edge: set wins, because the newer instruction's write is outstanding.
  - qN_pending = pending[qN_addr], and 0 for address 0.
  - In the cycle rf_we=1 for register r, qN_pending for r is still 1. Consumers stall one extra cycle; no forwarding is needed.
  - Issue to an already-pending register keeps the bit set. A single bit per register is sufficient because decode stalls WAW hazards.

Optional Feature:
- WB_LSU_BYPASS_EN defined:
  - When the FIFO is empty, no ALU winner exists, and an LSU handshake with lsu_rd!=0 occurs, that result goes straight to rf_* at the next edge and is not pushed.
  - Minimum LSU latency is one cycle.
- Not defined:
  - Every LSU result passes through the FIFO.
  - Minimum LSU latency is two cycles: push, pop, then present.

Decomposition:
- Package wb_pkg: XLEN, REG_AW=5, NREGS=32, and typedef wb_entry_t {rd[4:0], wd[XLEN-1:0]}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t.
  - Ports: push, pop, full, empty, count, head.
  - Same clk and asynchronous rst_n.

Test Plan:
- ALU only: alu_valid, rd=5, wd=0xDEADBEEF -> next cycle rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; then rf_we=0.
- Priority and ordering: ALU writes every cycle for 4 cycles while LSU pushes rd=6,7,8,9 -> lsu_ready drops after 4 pushes. When the ALU idles, writes appear in order 6,7,8,9.
- x0: alu rd=0 together with a queued LSU entry rd=3 -> rf_addr=3 written that cycle. LSU push rd=0 -> fifo_count unchanged and rf_we never asserted.
- Scoreboard: issue rd=10, then q1_addr=10 -> q1_pending=1 until the edge ending the rf_we/rf_addr=10 cycle. issue_rd=10 coinciding with that clear -> q1_pending stays 1.
- Reset mid-run: assert rst_n low with 3 entries queued and pending bits set -> immediately rf_we=0, fifo_count=0, q1_pending=q2_pending=0, and no write after release.
- With WB_LSU_BYPASS_EN, empty FIFO, ALU idle: LSU rd=4, wd=0x1234 -> rf_addr=4 at the next cycle and fifo_count stays 0. Without the macro, the same stimulus writes one cycle later.
